// File: rtl/axis_line_feeder.sv
// axis_line_feeder
// Streams a byte image from a one-cycle-latency memory to a solver over
// AXI-stream. 0xFF bytes act as line delimiters: they are never sent, and
// they mark the preceding data byte as the last beat of its line. After
// the last beat, the block waits for one 32-bit result word, with a
// timeout.
//
// Datapath: a read issued at a clock edge returns data in the next cycle.
// That byte is either absorbed at once or parked in a one-entry hold
// register. An absorbed byte goes into a pending register (the lookahead
// slot). A pending byte can only be classified, and so have its tlast
// decided, once the byte after it is known. The classified byte then moves
// into the output register that drives the AXI-stream transmit port.

module axis_line_feeder #(
  parameter  int MEM_LENGTH = 21529,
  parameter  int TIMEOUT    = 1024,
  localparam int AW         = $clog2(MEM_LENGTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          tvalid_tx,
  input  logic          tready_tx,
  output logic [7:0]    tdata_tx,
  output logic          tlast_tx,
  input  logic          tvalid_rx,
  output logic          tready_rx,
  input  logic [31:0]   tdata_rx,
  input  logic          tlast_rx,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic [31:0]   result,
  output logic [15:0]   line_count
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] END_ADDR = AW'(MEM_LENGTH);
  localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);
  localparam logic [7:0]    DELIM    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RESULT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [AW-1:0] addr;
  logic          rd_valid;
  logic          hold_valid;
  logic [7:0]    hold_data;
  logic          pend_valid;
  logic [7:0]    pend_data;
  logic [TW-1:0] wait_cnt;

  logic          src_valid;
  logic [7:0]    src_data;
  logic          src_delim;
  logic          out_free;
  logic          all_issued;
  logic          absorb;
  logic          flush_pend;
  logic          issue;
  logic          stream_end;
  logic          timeout_hit;
  logic          tx_last_hs;

  // tlast_rx is ignored: only the first result word of a run is captured.
  logic          unused;
  assign unused = tlast_rx;

  assign mem_addr = addr;

  // Datapath control: where the next byte comes from, and whether it can move on.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the block leaves a latch behind.
    src_valid   = hold_valid | rd_valid;
    src_data    = hold_valid ? hold_data : mem_rdata;
    src_delim   = (src_data == DELIM);
    out_free    = !tvalid_tx || tready_tx;
    all_issued  = (addr == END_ADDR);
    // A byte is absorbed when no pending byte is waiting, or when the
    // pending byte can move into the output register this cycle.
    absorb      = src_valid && (!pend_valid || out_free);
    // After the final read, the pending byte is the last data byte of the image.
    flush_pend  = !src_valid && all_issued && pend_valid && out_free;
    // A new read is issued only if its data is sure to find room next cycle.
    // The data goes either into the pipeline or into the empty hold slot.
    issue       = 1'b0;
    if (state == IDLE) begin
      issue = start;
    end else if (state == STREAM) begin
      issue = !all_issued && !hold_valid && !(rd_valid && !absorb);
    end
    // Everything has drained, and any beat still presented is the final one, leaving now.
    stream_end  = (state == STREAM) && all_issued && !src_valid && !pend_valid && out_free;
    timeout_hit = (state == WAIT_RESULT) && !abort && !tvalid_rx && (wait_cnt == WAIT_MAX);
    tx_last_hs  = tvalid_tx && tready_tx && tlast_tx;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        if (abort)           state_next = IDLE;
        else if (stream_end) state_next = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (abort)                     state_next = IDLE;
        else if (tvalid_rx)            state_next = DONE;
        else if (wait_cnt == WAIT_MAX) state_next = IDLE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy      = (state == STREAM) || (state == WAIT_RESULT);
    tready_rx = (state == WAIT_RESULT);
    done      = (state == DONE);
  end

  // Read pipeline, lookahead slot and transmit register; cleared outside STREAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      rd_valid   <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      tvalid_tx  <= 1'b0;
      tdata_tx   <= '0;
      tlast_tx   <= 1'b0;
    end else if (state_next != STREAM) begin
      addr       <= '0;
      rd_valid   <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      tvalid_tx  <= 1'b0;
      tdata_tx   <= '0;
      tlast_tx   <= 1'b0;
    end else begin
      rd_valid <= issue;
      if (issue) addr <= addr + AW'(1);

      // Park read data that cannot be absorbed; release the hold slot once it is consumed.
      if (rd_valid && !absorb) begin
        hold_valid <= 1'b1;
        hold_data  <= mem_rdata;
      end else if (absorb) begin
        hold_valid <= 1'b0;
      end

      // A delimiter empties the lookahead slot; a data byte takes it over.
      if (absorb) begin
        pend_valid <= !src_delim;
        pend_data  <= src_data;
      end else if (flush_pend) begin
        pend_valid <= 1'b0;
      end

      // The pending byte becomes a beat once its successor, or the end of the image, is known.
      if ((absorb && pend_valid) || flush_pend) begin
        tvalid_tx <= 1'b1;
        tdata_tx  <= pend_data;
        tlast_tx  <= flush_pend || src_delim;
      end else if (tready_tx) begin
        tvalid_tx <= 1'b0;
      end
    end
  end

  // Result-wait cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == WAIT_RESULT) begin
      wait_cnt <= wait_cnt + TW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Run status: result capture, sticky timeout and saturating line count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result      <= '0;
      timeout_err <= 1'b0;
      line_count  <= '0;
    end else begin
      if (state == IDLE && start) begin
        timeout_err <= 1'b0;
        line_count  <= '0;
      end else begin
        if (timeout_hit) timeout_err <= 1'b1;
        if (tx_last_hs && line_count != 16'hFFFF) line_count <= line_count + 16'd1;
      end
      if (state == WAIT_RESULT && tvalid_rx && !abort) result <= tdata_rx;
    end
  end

endmodule

// File: tb/tb_axis_line_feeder.sv
// Bench for axis_line_feeder: a 48-byte image memory, a stream sink with
// either constant or random tready, and a scripted solver response.

module tb_axis_line_feeder;

  localparam int ML = 48;
  localparam int TO = 16;
  localparam int AW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'h00;
  logic          tvalid_tx;
  logic          tready_tx = 1'b1;
  logic [7:0]    tdata_tx;
  logic          tlast_tx;
  logic          tvalid_rx = 1'b0;
  logic          tready_rx;
  logic [31:0]   tdata_rx = '0;
  logic          tlast_rx = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [31:0]   result;
  logic [15:0]   line_count;

  axis_line_feeder #(.MEM_LENGTH(ML), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tvalid_tx(tvalid_tx), .tready_tx(tready_tx), .tdata_tx(tdata_tx), .tlast_tx(tlast_tx),
    .tvalid_rx(tvalid_rx), .tready_rx(tready_rx), .tdata_rx(tdata_rx), .tlast_rx(tlast_rx),
    .busy(busy), .done(done), .timeout_err(timeout_err), .result(result), .line_count(line_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mem [ML];
  logic [8:0] got [$];
  logic [8:0] exp_q [$];
  bit         rnd_ready  = 1'b0;
  bit         chk_stable = 1'b0;
  bit         stalled_prev = 1'b0;
  logic [8:0] prev_beat = '0;

  typedef struct {
    logic [63:0] img;
    int          len;
    bit          rnd;
    bit          start_abort;
    logic [31:0] res;
    int          n_beats;
    logic [71:0] beats;
    int          lines;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
  endtask

  // Synchronous-read image memory: data valid one cycle after the address.
  always @(posedge clk) begin
    if (int'(mem_addr) < ML) mem_rdata <= mem[mem_addr];
    else mem_rdata <= 8'h00;
  end

  // Stream sink ready pattern.
  always @(negedge clk) begin
    if (rnd_ready) tready_tx = 1'($urandom_range(0, 1));
    else tready_tx = 1'b1;
  end

  // Beat collector and hold-while-stalled checker.
  always @(posedge clk) begin
    if (!rst && tvalid_tx && tready_tx) got.push_back({tlast_tx, tdata_tx});
    if (chk_stable && stalled_prev && !rst) begin
      check("stall_tvalid_held", {31'd0, tvalid_tx}, 32'd1);
      check("stall_beat_held", {23'd0, tlast_tx, tdata_tx}, {23'd0, prev_beat});
    end
    stalled_prev = !rst && tvalid_tx && !tready_tx;
    prev_beat    = {tlast_tx, tdata_tx};
  end

  function automatic void build_exp();
    exp_q.delete();
    for (int i = 0; i < ML; i++) begin
      if (mem[i] != 8'hFF) begin
        if (i == ML - 1) exp_q.push_back({1'b1, mem[i]});
        else exp_q.push_back({mem[i+1] == 8'hFF, mem[i]});
      end
    end
  endfunction

  task automatic pulse_start(input bit with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_rx(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (tready_rx) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_reached_wait"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic respond(input string tag, input logic [31:0] res);
    tdata_rx  = res;
    tvalid_rx = 1'b1;
    @(negedge clk);
    tvalid_rx = 1'b0;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
    check({tag, "_result"}, result, res);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_single"}, {31'd0, done}, 32'd0);
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_beat_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check($sformatf("%s_beat%0d", tag, i), {23'd0, got[i]}, {23'd0, exp_q[i]});
  endtask

  task automatic run_vec(input int idx);
    vec_t v = vecs[idx];
    string tag = $sformatf("vec%0d", idx);
    for (int i = 0; i < ML; i++) begin
      if (i < v.len) mem[i] = v.img[8*i +: 8];
      else mem[i] = 8'hFF;
    end
    exp_q.delete();
    for (int i = 0; i < v.n_beats; i++) exp_q.push_back(v.beats[9*i +: 9]);
    got.delete();
    rnd_ready  = v.rnd;
    chk_stable = v.rnd;
    pulse_start(v.start_abort);
    check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    wait_rx(tag);
    compare_beats(tag);
    check({tag, "_line_count"}, {16'd0, line_count}, v.lines);
    respond(tag, v.res);
    rnd_ready  = 1'b0;
    chk_stable = 1'b0;
  endtask

  task automatic run_model(input string tag, input bit rnd, input logic [31:0] res);
    build_exp();
    got.delete();
    rnd_ready  = rnd;
    chk_stable = rnd;
    pulse_start(1'b0);
    wait_rx(tag);
    compare_beats(tag);
    respond(tag, res);
    rnd_ready  = 1'b0;
    chk_stable = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] prev_res;

    // Hand-computed vectors; images are padded with 0xFF up to 48 bytes.
    vecs[0] = '{img: {24'd0, 8'hFF, 8'h03, 8'hFF, 8'h02, 8'h01}, len: 5, rnd: 1'b0,
                start_abort: 1'b0, res: 32'd42, n_beats: 3,
                beats: {45'd0, 9'h103, 9'h102, 9'h001}, lines: 2};
    vecs[1] = '{img: {16'd0, 8'h08, 8'hFF, 8'hFF, 8'h07, 8'hFF, 8'hFF}, len: 6, rnd: 1'b0,
                start_abort: 1'b0, res: 32'h1234, n_beats: 2,
                beats: {54'd0, 9'h108, 9'h107}, lines: 2};
    vecs[2] = '{img: {24'd0, 8'hFF, 8'h03, 8'hFF, 8'h02, 8'h01}, len: 5, rnd: 1'b1,
                start_abort: 1'b0, res: 32'd43, n_beats: 3,
                beats: {45'd0, 9'h103, 9'h102, 9'h001}, lines: 2};
    vecs[3] = '{img: {40'd0, 8'h07, 8'h06, 8'h05}, len: 3, rnd: 1'b0,
                start_abort: 1'b1, res: 32'd7, n_beats: 3,
                beats: {45'd0, 9'h107, 9'h006, 9'h005}, lines: 1};
    vecs[4] = '{img: 64'd0, len: 0, rnd: 1'b0,
                start_abort: 1'b0, res: 32'd99, n_beats: 0,
                beats: 72'd0, lines: 0};

    for (int i = 0; i < ML; i++) mem[i] = 8'hFF;

    // Outputs held at zero while reset is asserted.
    #1;
    check("rst_tvalid", {31'd0, tvalid_tx}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_line_count", {16'd0, line_count}, 32'd0);
    check("rst_tready_rx", {31'd0, tready_rx}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Random 48-byte image: constant-ready and random-ready runs against the model.
    for (int i = 0; i < ML; i++)
      mem[i] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    run_model("rnd_img_ready", 1'b0, 32'hA5A5_0001);
    run_model("rnd_img_bp", 1'b1, 32'hA5A5_0002);

    // Timeout: no solver response for TO cycles.
    prev_res = result;
    pulse_start(1'b0);
    wait_rx("to");
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (!tready_rx) break;
      n++;
      @(negedge clk);
    end
    check("to_wait_cycles", n, TO);
    check("to_err_set", {31'd0, timeout_err}, 32'd1);
    check("to_busy_low", {31'd0, busy}, 32'd0);
    check("to_result_kept", result, prev_res);
    pulse_start(1'b0);
    check("to_err_cleared", {31'd0, timeout_err}, 32'd0);
    wait_rx("to_next");
    respond("to_next", 32'd5);

    // Result arriving in the last allowed wait cycle wins over the timeout.
    pulse_start(1'b0);
    wait_rx("edge");
    repeat (TO - 1) @(negedge clk);
    check("edge_still_waiting", {31'd0, tready_rx}, 32'd1);
    tdata_rx  = 32'hCAFE;
    tvalid_rx = 1'b1;
    @(negedge clk);
    tvalid_rx = 1'b0;
    check("edge_done", {31'd0, done}, 32'd1);
    check("edge_result", result, 32'hCAFE);
    check("edge_no_timeout", {31'd0, timeout_err}, 32'd0);

    // Abort while the 5th beat is on the bus, then a full restream.
    for (int i = 0; i < ML; i++) mem[i] = 8'(i + 1);
    prev_res = result;
    got.delete();
    pulse_start(1'b0);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      if (got.size() == 4 && tvalid_tx) begin
        n = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reached_beat5", n, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_tvalid_low", {31'd0, tvalid_tx}, 32'd0);
    check("abort_busy_low", {31'd0, busy}, 32'd0);
    check("abort_result_kept", result, prev_res);
    run_model("after_abort", 1'b0, 32'd77);

    // Reset pulse between clock edges in the middle of a stream.
    pulse_start(1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tvalid", {31'd0, tvalid_tx}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_mem_addr", {26'd0, mem_addr}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_line_count", {16'd0, line_count}, 32'd0);
    @(negedge clk);
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_idle", {31'd0, busy}, 32'd0);
    run_model("after_rst", 1'b0, 32'd88);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axis_line_feeder.md
AXIS_LINE_FEEDER -- requirements
Module: axis_line_feeder

Interface
REQ-001 Parameter MEM_LENGTH, default 21529, number of bytes in the puzzle-input memory image.
REQ-002 Parameter TIMEOUT, default 1024, max cycles to wait for the solver result after the final beat.
REQ-003 Derived width AW = $clog2(MEM_LENGTH+1).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to stream the whole image.
REQ-007 abort  in  1  synchronous cancel of a run in progress.
REQ-008 mem_addr  out  AW  byte address into the image memory.
REQ-009 mem_rdata  in  8  image byte; valid exactly one cycle after mem_addr is presented.
REQ-010 tvalid_tx, tready_tx (in), tdata_tx[7:0], tlast_tx  AXI-stream bytes to solver.
REQ-011 tvalid_rx (in), tready_rx, tdata_rx[31:0] (in), tlast_rx (in)  AXI-stream result from solver.
REQ-012 busy  out  1  high from accepted start until DONE or IDLE is reached.
REQ-013 done  out  1  one-cycle pulse when a result is captured.
REQ-014 timeout_err  out  1  sticky until next accepted start.
REQ-015 result  out  32  last captured solver result.
REQ-016 line_count  out  16  number of beats sent with tlast=1 in the current/last run.

Function
REQ-017 States: IDLE, STREAM, WAIT_RESULT, DONE; DONE lasts exactly one cycle then returns to IDLE.
REQ-018 IDLE -> STREAM on start=1; start ignored in every other state.
REQ-019 In STREAM, addresses 0..MEM_LENGTH-1 are read strictly in order, each exactly once.
REQ-020 Byte 0xFF is a line delimiter and is never emitted as a beat.
REQ-021 Every non-0xFF byte is emitted as one beat, in memory order, unmodified.
REQ-022 tlast_tx=1 on a beat iff the next memory byte is 0xFF or the beat is the final non-0xFF byte of the image.
REQ-023 Leading 0xFF and consecutive 0xFF bytes produce no beat and no extra tlast.
REQ-024 Once tvalid_tx=1, tvalid_tx, tdata_tx, tlast_tx hold stable until tready_tx=1 at a rising edge.
REQ-025 Backpressure stalls mem_addr advance; no byte is lost or duplicated under any tready_tx pattern.
REQ-026 With tready_tx held high, first tvalid_tx within 3 cycles of start; sustained one beat per cycle except at most one bubble per 0xFF byte.
REQ-027 STREAM -> WAIT_RESULT on handshake of the final tlast beat; image with no non-0xFF bytes goes directly to WAIT_RESULT.
REQ-028 tready_rx=1 only in WAIT_RESULT; on tvalid_rx=1 result <= tdata_rx, next state DONE, done=1 for that cycle.
REQ-029 tlast_rx is ignored; only the first result word of a run is captured.
REQ-030 Wait counter increments each WAIT_RESULT cycle; reaching TIMEOUT sets timeout_err=1, state -> IDLE, result unchanged.
REQ-031 tvalid_rx and timeout in the same cycle: result captured, timeout_err stays 0.
REQ-032 line_count clears on accepted start, increments per tlast beat handshake, saturates at 16'hFFFF.
REQ-033 abort=1 in STREAM or WAIT_RESULT: next cycle state IDLE, tvalid_tx=0, tready_rx=0, busy=0, result unchanged; abort ignored in IDLE.
REQ-034 abort and start both high in IDLE: start wins.

Reset
REQ-035 During rst=1 all outputs low/zero: tvalid_tx, tlast_tx, tdata_tx, tready_rx, busy, done, timeout_err, result, line_count, mem_addr; state IDLE.
REQ-036 rst asserted mid-run takes effect immediately without waiting for clk; after release block waits for a new start.

Verification
REQ-037 Image "1 2 FF 3 FF", tready_tx=1 -> beats 1,2(last),3(last); line_count=2; solver returns 32'd42 -> result=42, done one pulse.
REQ-038 Image "FF FF 7 FF FF 8" -> beats 7(last),8(last); no beat for 0xFF; line_count=2.
REQ-039 Random tready_tx with 50% duty on 48-byte image -> beat sequence identical to tready_tx=1 run; tdata/tlast stable while stalled.
REQ-040 No tvalid_rx for TIMEOUT=16 cycles -> timeout_err=1, state IDLE, result keeps prior value; next start clears timeout_err.
REQ-041 abort on 5th beat -> tvalid_tx low next cycle, busy=0; following start restreams from address 0.
REQ-042 rst pulse mid-STREAM between clock edges -> outputs zero immediately; start after release yields full correct stream.
